// File: rtl/myproject_mul_share_arb_if.sv
// Operand/result bus between the datapath engines and the shared multiplier
// arbiter. The arbiter takes the slave modport and the engines take the master.
interface myproject_mul_share_arb_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int A_W   = 24,
    parameter int B_W   = 18,
    parameter int P_W   = 37
);
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*A_W-1:0] req_a;
    logic [N_REQ*B_W-1:0] req_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [P_W-1:0]       res_data;
    logic [ID_W-1:0]      res_id;
    logic [15:0]          grant_cnt;

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id, grant_cnt
    );

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id, grant_cnt
    );
endinterface

// File: rtl/myproject_mul_share_arb.sv
// Round-robin time-sharing of one unsigned A_W x B_W multiplier between
// N_REQ requesters. One registered result slot; a new grant is issued only
// when that slot is empty or being drained in the same cycle.
module myproject_mul_share_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int A_W   = 24,
    parameter int B_W   = 18,
    parameter int P_W   = 37
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    myproject_mul_share_arb_if.slave bus
);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  winner;
    logic             any_req;
    logic             slot_free;
    logic [N_REQ-1:0] grant;
    logic             hs;

    logic             res_valid_q;
    logic [P_W-1:0]   res_data_q;
    logic [ID_W-1:0]  res_id_q;
    logic [15:0]      grant_cnt_q;

    logic [A_W-1:0]   a_arr [N_REQ];
    logic [B_W-1:0]   b_arr [N_REQ];
    logic [A_W-1:0]   a_sel;
    logic [B_W-1:0]   b_sel;
    logic [P_W-1:0]   prod;

    // Unpack the flat operand buses into per-requester lanes
    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign a_arr[g] = bus.req_a[g*A_W +: A_W];
        assign b_arr[g] = bus.req_b[g*B_W +: B_W];
    end

    assign slot_free = !res_valid_q || bus.res_ready;

    // Rotating priority search: walk offsets high to low so the valid
    // requester closest to rr_ptr is the one left standing
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            logic [ID_W-1:0] idx;
            idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (bus.req_valid[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

    // One-hot grant; held off while in reset or while the result slot is stuck
    always_comb begin
        grant = '0;
        if (ap_rst_n && slot_free && any_req)
            grant[winner] = 1'b1;
    end

    assign hs    = |(bus.req_valid & grant);
    assign a_sel = a_arr[winner];
    assign b_sel = b_arr[winner];
    // Operating at P_W bits directly yields the low P_W bits of the full product
    assign prod  = P_W'(a_sel) * P_W'(b_sel);

    // Result slot, round-robin pointer and grant counter
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            rr_ptr      <= '0;
            grant_cnt_q <= '0;
        end else if (hs) begin
            res_valid_q <= 1'b1;
            res_data_q  <= prod;
            res_id_q    <= winner;
            rr_ptr      <= ID_W'((int'(winner) + 1) % N_REQ);
            grant_cnt_q <= grant_cnt_q + 16'd1;
        end else if (bus.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready = grant;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Randomized and directed checks of the shared-multiplier arbiter against a
// cycle-level reference model of its grant and result rules.
module tb_myproject_mul_share_arb;
    localparam int N    = 4;
    localparam int ID_W = 2;
    localparam int A_W  = 24;
    localparam int B_W  = 18;
    localparam int P_W  = 37;

    logic ap_clk;
    logic ap_rst_n;

    myproject_mul_share_arb_if #(.N_REQ(N), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)) bus ();

    myproject_mul_share_arb #(.N_REQ(N), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus
    logic [N-1:0]   v_in;
    logic [A_W-1:0] a_in [N];
    logic [B_W-1:0] b_in [N];
    logic           rdy_in;

    // reference model state
    bit          m_valid;
    logic [63:0] m_data;
    int          m_id;
    int          m_ptr;
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*A_W +: A_W] = a_in[i];
            bus.req_b[i*B_W +: B_W] = b_in[i];
        end
        bus.req_valid = v_in;
        bus.res_ready = rdy_in;
    endtask

    function automatic int pick();
        if (m_valid && !rdy_in) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (v_in[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [63:0] mul_ref(input int i);
        logic [63:0] p;
        p = 64'(a_in[i]) * 64'(b_in[i]);
        return p & ((64'd1 << P_W) - 64'd1);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
    endtask

    // Called at a negedge: drive, check combinational grant, clock, check results
    task automatic step(input string tag);
        int w;
        logic [N-1:0] exp_rdy;
        drive();
        #1;
        w = pick();
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'(exp_rdy));
        @(posedge ap_clk);
        if (w >= 0) begin
            m_data  = mul_ref(w);
            m_id    = w;
            m_valid = 1;
            m_ptr   = (w + 1) % N;
            m_cnt   = (m_cnt + 1) % 65536;
        end else if (rdy_in) begin
            m_valid = 0;
        end
        @(negedge ap_clk);
        chk({tag, ".res_valid"}, 64'(bus.res_valid), 64'(m_valid));
        chk({tag, ".grant_cnt"}, 64'(bus.grant_cnt), 64'(m_cnt));
        if (m_valid) begin
            chk({tag, ".res_data"}, 64'(bus.res_data), m_data);
            chk({tag, ".res_id"},   64'(bus.res_id),   64'(m_id));
        end
    endtask

    initial begin
        logic [P_W-1:0] held_data;
        logic [ID_W-1:0] held_id;
        int prev_id;

        ap_rst_n = 1'b0;
        v_in = '0; rdy_in = 1'b0;
        for (int i = 0; i < N; i++) begin a_in[i] = '0; b_in[i] = '0; end
        drive();
        v_in = '1; drive();
        model_reset();
        repeat (2) @(negedge ap_clk);
        chk("rst.req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst.res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst.res_data",  64'(bus.res_data),  64'd0);
        chk("rst.res_id",    64'(bus.res_id),    64'd0);
        chk("rst.grant_cnt", 64'(bus.grant_cnt), 64'd0);
        ap_rst_n = 1'b1;

        // single request
        v_in = 4'b0001; a_in[0] = 24'd1000; b_in[0] = 18'd3; rdy_in = 1'b1;
        step("single");
        chk("single.data_const", 64'(bus.res_data), 64'd3000);
        chk("single.cnt_const",  64'(bus.grant_cnt), 64'd1);

        // truncation
        a_in[0] = 24'hFFFFFF; b_in[0] = 18'h3FFFF;
        step("trunc");
        chk("trunc.data_const", 64'(bus.res_data), 64'h1FFEFC0001);

        // all valid, streaming round robin
        v_in = 4'b1111;
        prev_id = -1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) begin
                a_in[i] = A_W'($urandom); b_in[i] = B_W'($urandom);
            end
            step("rr");
            if (prev_id >= 0)
                chk("rr.sequence", 64'(bus.res_id), 64'((prev_id + 1) % N));
            prev_id = int'(bus.res_id);
        end

        // backpressure with everything pending
        rdy_in = 1'b0;
        held_data = bus.res_data;
        held_id   = bus.res_id;
        for (int c = 0; c < 5; c++) begin
            step("bp");
            chk("bp.hold_data", 64'(bus.res_data), 64'(held_data));
            chk("bp.hold_id",   64'(bus.res_id),   64'(held_id));
        end
        rdy_in = 1'b1;
        step("bp_resume");
        chk("bp_resume.id", 64'(bus.res_id), 64'((held_id + 1) % N));

        // steer pointer to 2, then 4'b1001 must go 3 then 0
        v_in = 4'b0010;
        step("skip_setup");
        v_in = 4'b1001;
        step("skip1");
        chk("skip1.id_const", 64'(bus.res_id), 64'd3);
        step("skip2");
        chk("skip2.id_const", 64'(bus.res_id), 64'd0);

        // asynchronous reset mid-stream with a result held
        v_in = 4'b1111;
        step("pre_rst");
        #2 ap_rst_n = 1'b0;
        #1;
        chk("arst.res_valid", 64'(bus.res_valid), 64'd0);
        chk("arst.grant_cnt", 64'(bus.grant_cnt), 64'd0);
        chk("arst.req_ready", 64'(bus.req_ready), 64'd0);
        model_reset();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step("post_rst");
        chk("post_rst.id_const", 64'(bus.res_id), 64'd0);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            v_in   = N'($urandom);
            rdy_in = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                a_in[i] = A_W'($urandom); b_in[i] = B_W'($urandom);
            end
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/myproject_mul_share_arb.md
Name: myproject_mul_share_arb

Overview:
- Round-robin arbiter and sequencer that time-shares one 24-bit x 18-bit unsigned multiplier (37-bit truncated product) between N_REQ requesters.
- Sits between the layer datapath engines and the multiplier.
- Accepts operand pairs over per-requester valid/ready and returns each product with the requester index on one registered result channel with backpressure.
- The multiplier is instantiated inside this block.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- ID_W, 2, requester index width; must equal clog2(N_REQ).
- A_W, 24, operand A width, unsigned.
- B_W, 18, operand B width, unsigned.
- P_W, 37, product width; keeps the low P_W bits of the full A_W+B_W product.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  N_REQ  bit i: requester i presents an operand pair.
- req_ready  out  N_REQ  bit i: requester i is granted this cycle (one-hot or zero).
- req_a  in  N_REQ*A_W  packed operand A; requester i at bits [i*A_W +: A_W].
- req_b  in  N_REQ*B_W  packed operand B; requester i at bits [i*B_W +: B_W].
- res_valid  out  1  result register holds a valid product.
- res_ready  in  1  consumer accepts the result.
- res_data  out  P_W  registered product.
- res_id  out  ID_W  index of the requester that produced res_data.
- grant_cnt  out  16  wrapping count of accepted requests (debug).

Behaviour:
- Reset (ap_rst_n low, asynchronous):
  - res_valid=0, res_data=0, res_id=0, grant_cnt=0, rr_ptr=0.
  - req_ready=0 while reset is held.
  - Any in-flight result is discarded. Nothing is accepted in the cycle that reset releases on; operation starts at the first rising edge after release.
- Slot free: slot_free = !res_valid | res_ready.
- Grant:
  - Only when slot_free=1 and some req_valid bit is set.
  - Winner is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ.
  - req_ready = one-hot of the winner, combinationally. req_ready=0 when slot_free=0 or no request is valid.
  - A handshake on requester i is req_valid[i] & req_ready[i]. The requester may change operands in the following cycle.
- Datapath:
  - Mux the winner's req_a/req_b into the multiplier.
  - Product = zero-extended A * zero-extended B, truncated to the low P_W bits.
  - On a handshake at edge t: res_data <= product, res_id <= winner, res_valid <= 1, rr_ptr <= (winner+1) mod N_REQ, grant_cnt <= grant_cnt+1 (wraps 0xFFFF -> 0).
  - Latency: handshake cycle to res_valid is exactly 1 cycle.
  - Throughput: 1 product/cycle when res_ready is held high.
- Result channel:
  - res_valid & res_ready with no new grant -> res_valid <= 0.
  - res_valid & !res_ready -> res_data, res_id and res_valid hold stable, no grant is issued, all req_ready=0.
  - Simultaneous drain and grant: the new result replaces the old one in the same edge. There is no bubble.
- Fairness:
  - rr_ptr changes only on a grant.
  - A continuously asserting requester waits at most N_REQ-1 grants.
- Requester dropping req_valid without a handshake is legal. It is not an error and leaves no state behind.
- No combinational path from res_ready to res_data or res_id. The res_ready -> req_ready path is allowed.

Test Plan:
- Reset then single request: req_valid=4'b0001, a=24'd1000, b=18'd3 -> req_ready=4'b0001 same cycle; next cycle res_valid=1, res_data=37'd3000, res_id=0, grant_cnt=1.
- Truncation: a=24'hFFFFFF, b=18'h3FFFF -> res_data=37'h1FFEFC0001.
- All four requesters valid continuously, res_ready=1 -> grants in order 0,1,2,3,0,...; one result per cycle; res_id follows the same sequence.
- Backpressure: res_ready=0 for 5 cycles with all requesters valid -> req_ready=0 and res_data/res_id stable for all 5 cycles; on res_ready=1, grant resumes at rr_ptr with no lost or duplicated result.
- Pointer skip: rr_ptr=2, req_valid=4'b1001 -> grant 3, then rr_ptr=0 -> grant 0.
- ap_rst_n pulsed low mid-stream with res_valid=1 -> res_valid=0 and grant_cnt=0 immediately (asynchronously); after release the next grant goes to requester 0.
